// File: rtl/stream_emitter.sv
// Avalon-ST playback engine: on go, reads one window of samples from the output
// buffer and presents each frame to the codec's left/right sinks, then pulses done.
module stream_emitter #(
  parameter int DATA_W  = 16,
  parameter int WIN_LEN = 512,
  parameter int NUM_WIN = 4,
  parameter int STEREO  = 0,
  parameter int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
  parameter int AW      = (NUM_WIN * WIN_LEN > 1) ? $clog2(NUM_WIN * WIN_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIN_W-1:0]  window_start,
  input  logic              go_in,
  output logic              go_out,
  output logic              done,
  output logic              win_err,
  output logic [AW-1:0]     buf_addr,
  output logic              buf_rden,
  input  logic [2*DATA_W-1:0] buf_rdata,
  output logic [DATA_W-1:0] left_out_data,
  output logic              left_out_valid,
  input  logic              left_out_ready,
  output logic [DATA_W-1:0] right_out_data,
  output logic              right_out_valid,
  input  logic              right_out_ready,
  output logic [2:0]        dbg_state
);

  localparam int CW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_LATCH   = 3'd2,
    S_PRESENT = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                rden_q, rden_d;
  logic [DATA_W-1:0]   ldata_q, ldata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                lvalid_q, lvalid_d;
  logic                rvalid_q, rvalid_d;
  logic                done_q, done_d;
  logic                win_err_q, win_err_d;
  logic                go_out_q, go_out_d;
  logic [AW-1:0]       start_base;
  logic [CW-1:0]       cnt_inc;
  logic                win_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      rden_q    <= 1'b0;
      ldata_q   <= '0;
      rdata_q   <= '0;
      lvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      win_err_q <= 1'b0;
      go_out_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rden_q    <= rden_d;
      ldata_q   <= ldata_d;
      rdata_q   <= rdata_d;
      lvalid_q  <= lvalid_d;
      rvalid_q  <= rvalid_d;
      done_q    <= done_d;
      win_err_q <= win_err_d;
      go_out_q  <= go_out_d;
    end
  end

  // Valid/ready: a channel transfers on a rising edge where its valid and ready
  // are both 1; valid then drops and data is frozen while valid stays high.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rden_d     = 1'b0;
    ldata_d    = ldata_q;
    rdata_d    = rdata_q;
    lvalid_d   = lvalid_q;
    rvalid_d   = rvalid_q;
    done_d     = 1'b0;
    win_err_d  = 1'b0;
    go_out_d   = go_out_q;
    start_base = AW'(window_start) * AW'(WIN_LEN);
    cnt_inc    = cnt_q + CW'(1);
    win_ok     = 32'(window_start) < 32'(NUM_WIN);

    case (state_q)
      S_IDLE: begin
        if (go_in) begin
          if (win_ok) begin
            base_d   = start_base;
            cnt_d    = '0;
            addr_d   = start_base;
            rden_d   = 1'b1;
            go_out_d = 1'b0;
            state_d  = S_READ;
          end else begin
            win_err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        ldata_d  = buf_rdata[DATA_W-1:0];
        if (STEREO != 0) rdata_d = buf_rdata[2*DATA_W-1:DATA_W];
        else             rdata_d = buf_rdata[DATA_W-1:0];
        lvalid_d = 1'b1;
        rvalid_d = 1'b1;
        state_d  = S_PRESENT;
      end
      S_PRESENT: begin
        lvalid_d = lvalid_q & ~left_out_ready;
        rvalid_d = rvalid_q & ~right_out_ready;
        // Advance only once both channels have taken the frame.
        if (!lvalid_d && !rvalid_d) begin
          if (cnt_q == CW'(WIN_LEN - 1)) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            cnt_d   = cnt_inc;
            addr_d  = base_q + AW'(cnt_inc);
            rden_d  = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        go_out_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign go_out          = go_out_q;
  assign done            = done_q;
  assign win_err         = win_err_q;
  assign buf_addr        = addr_q;
  assign buf_rden        = rden_q;
  assign left_out_data   = ldata_q;
  assign left_out_valid  = lvalid_q;
  assign right_out_data  = rdata_q;
  assign right_out_valid = rvalid_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_stream_emitter.sv
// Bench for stream_emitter: a stereo and a mono instance (WIN_LEN=4, NUM_WIN=3)
// fed from a shared buffer model, checked against scoreboard queues.
module tb_stream_emitter;
  localparam int DW = 16;
  localparam int WL = 4;
  localparam int NW = 3;
  localparam int WW = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic lready, rready;
  logic [31:0] mem [0:11];

  // stereo instance
  logic [WW-1:0] s_ws;
  logic s_go, s_go_out, s_done, s_win_err, s_rden, s_lvalid, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [31:0] s_rdata;
  logic [DW-1:0] s_ldata, s_rdata_out;
  logic [2:0] s_state;

  // mono instance
  logic [WW-1:0] m_ws;
  logic m_go, m_go_out, m_done, m_win_err, m_rden, m_lvalid, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [31:0] m_rdata;
  logic [DW-1:0] m_ldata, m_rdata_out;
  logic [2:0] m_state;

  stream_emitter #(.DATA_W(DW), .WIN_LEN(WL), .NUM_WIN(NW), .STEREO(1)) u_stereo (
    .clk(clk), .reset_n(reset_n), .window_start(s_ws), .go_in(s_go),
    .go_out(s_go_out), .done(s_done), .win_err(s_win_err),
    .buf_addr(s_addr), .buf_rden(s_rden), .buf_rdata(s_rdata),
    .left_out_data(s_ldata), .left_out_valid(s_lvalid), .left_out_ready(lready),
    .right_out_data(s_rdata_out), .right_out_valid(s_rvalid), .right_out_ready(rready),
    .dbg_state(s_state)
  );

  stream_emitter #(.DATA_W(DW), .WIN_LEN(WL), .NUM_WIN(NW), .STEREO(0)) u_mono (
    .clk(clk), .reset_n(reset_n), .window_start(m_ws), .go_in(m_go),
    .go_out(m_go_out), .done(m_done), .win_err(m_win_err),
    .buf_addr(m_addr), .buf_rden(m_rden), .buf_rdata(m_rdata),
    .left_out_data(m_ldata), .left_out_valid(m_lvalid), .left_out_ready(lready),
    .right_out_data(m_rdata_out), .right_out_valid(m_rvalid), .right_out_ready(rready),
    .dbg_state(m_state)
  );

  always @(posedge clk) begin
    if (s_rden) s_rdata <= mem[s_addr];
    if (m_rden) m_rdata <= mem[m_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_l_q[$];
  logic [DW-1:0] exp_r_q[$];
  logic [AW-1:0] exp_ma_q[$];
  logic [DW-1:0] exp_ml_q[$];
  logic [DW-1:0] exp_mr_q[$];

  int s_rden_cnt, s_lhs_cnt, s_rhs_cnt, s_done_cnt;
  int m_rden_cnt, m_lhs_cnt, m_rhs_cnt, m_done_cnt;
  logic p_lvalid, p_lhs, p_rvalid, p_rhs;
  logic [DW-1:0] p_ldata, p_rdata;

  // Stereo monitor: pops expectations as the DUT reads and hands off frames.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!reset_n) begin
      p_lvalid = 1'b0; p_lhs = 1'b0; p_rvalid = 1'b0; p_rhs = 1'b0;
    end else begin
      if (s_rden) begin
        s_rden_cnt++;
        checks++;
        if (exp_a_q.size() == 0) begin
          errors++;
          $display("FAIL s_addr_unexpected actual=%0d required=no_read", s_addr);
        end else begin
          ea = exp_a_q.pop_front();
          if (s_addr !== ea) begin
            errors++;
            $display("FAIL s_addr actual=%0d required=%0d", s_addr, ea);
          end
        end
      end
      if (s_lvalid && lready) begin
        s_lhs_cnt++;
        checks++;
        if (exp_l_q.size() == 0) begin
          errors++;
          $display("FAIL s_left_unexpected actual=%h required=none", s_ldata);
        end else begin
          ed = exp_l_q.pop_front();
          if (s_ldata !== ed) begin
            errors++;
            $display("FAIL s_left_data actual=%h required=%h", s_ldata, ed);
          end
        end
      end
      if (s_rvalid && rready) begin
        s_rhs_cnt++;
        checks++;
        if (exp_r_q.size() == 0) begin
          errors++;
          $display("FAIL s_right_unexpected actual=%h required=none", s_rdata_out);
        end else begin
          ed = exp_r_q.pop_front();
          if (s_rdata_out !== ed) begin
            errors++;
            $display("FAIL s_right_data actual=%h required=%h", s_rdata_out, ed);
          end
        end
      end
      if (s_lvalid && p_lvalid && !p_lhs) begin
        checks++;
        if (s_ldata !== p_ldata) begin
          errors++;
          $display("FAIL s_left_stable actual=%h required=%h", s_ldata, p_ldata);
        end
      end
      if (s_rvalid && p_rvalid && !p_rhs) begin
        checks++;
        if (s_rdata_out !== p_rdata) begin
          errors++;
          $display("FAIL s_right_stable actual=%h required=%h", s_rdata_out, p_rdata);
        end
      end
      if (s_done) s_done_cnt++;
      p_lvalid = s_lvalid; p_lhs = s_lvalid && lready; p_ldata = s_ldata;
      p_rvalid = s_rvalid; p_rhs = s_rvalid && rready; p_rdata = s_rdata_out;
    end
  end

  // Mono monitor.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (reset_n) begin
      if (m_rden) begin
        m_rden_cnt++;
        checks++;
        if (exp_ma_q.size() == 0) begin
          errors++;
          $display("FAIL m_addr_unexpected actual=%0d required=no_read", m_addr);
        end else begin
          ea = exp_ma_q.pop_front();
          if (m_addr !== ea) begin
            errors++;
            $display("FAIL m_addr actual=%0d required=%0d", m_addr, ea);
          end
        end
      end
      if (m_lvalid && lready) begin
        m_lhs_cnt++;
        checks++;
        if (exp_ml_q.size() == 0) begin
          errors++;
          $display("FAIL m_left_unexpected actual=%h required=none", m_ldata);
        end else begin
          ed = exp_ml_q.pop_front();
          if (m_ldata !== ed) begin
            errors++;
            $display("FAIL m_left_data actual=%h required=%h", m_ldata, ed);
          end
        end
      end
      if (m_rvalid && rready) begin
        m_rhs_cnt++;
        checks++;
        if (exp_mr_q.size() == 0) begin
          errors++;
          $display("FAIL m_right_unexpected actual=%h required=none", m_rdata_out);
        end else begin
          ed = exp_mr_q.pop_front();
          if (m_rdata_out !== ed) begin
            errors++;
            $display("FAIL m_right_data actual=%h required=%h", m_rdata_out, ed);
          end
        end
      end
      if (m_done) m_done_cnt++;
    end
  end

  task automatic clear_counts();
    s_rden_cnt = 0; s_lhs_cnt = 0; s_rhs_cnt = 0; s_done_cnt = 0;
    m_rden_cnt = 0; m_lhs_cnt = 0; m_rhs_cnt = 0; m_done_cnt = 0;
  endtask

  task automatic flush_queues();
    exp_a_q.delete(); exp_l_q.delete(); exp_r_q.delete();
    exp_ma_q.delete(); exp_ml_q.delete(); exp_mr_q.delete();
  endtask

  task automatic push_stereo(input int w);
    for (int i = 0; i < WL; i++) begin
      int a;
      logic [31:0] word;
      a = w * WL + i;
      word = mem[a];
      exp_a_q.push_back(AW'(a));
      exp_l_q.push_back(word[15:0]);
      exp_r_q.push_back(word[31:16]);
    end
  endtask

  task automatic push_mono(input int w);
    for (int i = 0; i < WL; i++) begin
      int a;
      logic [31:0] word;
      a = w * WL + i;
      word = mem[a];
      exp_ma_q.push_back(AW'(a));
      exp_ml_q.push_back(word[15:0]);
      exp_mr_q.push_back(word[15:0]);
    end
  endtask

  task automatic go_stereo(input logic [WW-1:0] w);
    @(posedge clk); #1 s_ws = w; s_go = 1'b1;
    @(posedge clk); #1 s_go = 1'b0;
  endtask

  task automatic wait_done_s(input int maxc, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < maxc && !ok) begin
      @(negedge clk); n++;
      if (s_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; lready = 1'b0; rready = 1'b0;
    s_go = 1'b0; s_ws = '0; m_go = 1'b0; m_ws = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    checks++; if (s_go_out !== 1'b1) begin errors++; $display("FAIL rst_go_out actual=%b required=1", s_go_out); end
    checks++; if (s_done !== 1'b0 || s_win_err !== 1'b0) begin errors++; $display("FAIL rst_pulses actual=%b%b required=00", s_done, s_win_err); end
    checks++; if (s_rden !== 1'b0 || s_addr !== '0) begin errors++; $display("FAIL rst_buf actual=%b/%0d required=0/0", s_rden, s_addr); end
    checks++; if (s_lvalid !== 1'b0 || s_rvalid !== 1'b0) begin errors++; $display("FAIL rst_valid actual=%b%b required=00", s_lvalid, s_rvalid); end
    checks++; if (s_ldata !== '0 || s_rdata_out !== '0) begin errors++; $display("FAIL rst_data actual=%h/%h required=0/0", s_ldata, s_rdata_out); end
    checks++; if (s_state !== 3'd0 || m_go_out !== 1'b1) begin errors++; $display("FAIL rst_state actual=%0d/%b required=0/1", s_state, m_go_out); end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_stereo();
    int n; bit ok;
    clear_counts();
    lready = 1'b1; rready = 1'b1;
    push_stereo(2);
    go_stereo(2'd2);
    @(negedge clk);
    checks++; if (s_go_out !== 1'b0) begin errors++; $display("FAIL st_go_out_busy actual=%b required=0", s_go_out); end
    checks++; if (s_rden !== 1'b1) begin errors++; $display("FAIL st_first_rden actual=%b required=1", s_rden); end
    @(negedge clk); @(negedge clk);
    checks++; if (s_lvalid !== 1'b1 || s_rvalid !== 1'b1) begin errors++; $display("FAIL st_first_valid actual=%b%b required=11", s_lvalid, s_rvalid); end
    wait_done_s(40, n, ok);
    n = n + 3;
    checks++; if (!ok) begin errors++; $display("FAIL st_done_timeout actual=none required=done"); end
    checks++; if (n !== 13) begin errors++; $display("FAIL st_done_latency actual=%0d required=13", n); end
    @(negedge clk);
    checks++; if (s_go_out !== 1'b1 || s_done !== 1'b0) begin errors++; $display("FAIL st_after_done actual=%b%b required=10", s_go_out, s_done); end
    checks++; if (s_lhs_cnt !== WL || s_rhs_cnt !== WL || s_done_cnt !== 1) begin errors++; $display("FAIL st_counts actual=%0d/%0d/%0d required=4/4/1", s_lhs_cnt, s_rhs_cnt, s_done_cnt); end
    checks++; if (exp_a_q.size() != 0 || exp_l_q.size() != 0 || exp_r_q.size() != 0) begin errors++; $display("FAIL st_leftover actual=%0d required=0", exp_l_q.size()); end
  endtask

  task automatic test_mono();
    int n;
    clear_counts();
    lready = 1'b1; rready = 1'b1;
    mem[4] = 32'hABCD1234;
    mem[6] = 32'hABCD1234;
    push_mono(1);
    @(posedge clk); #1 m_ws = 2'd1; m_go = 1'b1;
    @(posedge clk); #1 m_go = 1'b0;
    n = 0;
    while (n < 40 && m_done_cnt == 0) begin @(negedge clk); n++; end
    checks++; if (m_done_cnt !== 1) begin errors++; $display("FAIL mono_done actual=%0d required=1", m_done_cnt); end
    checks++; if (m_lhs_cnt !== WL || m_rhs_cnt !== WL) begin errors++; $display("FAIL mono_counts actual=%0d/%0d required=4/4", m_lhs_cnt, m_rhs_cnt); end
    checks++; if (exp_ml_q.size() != 0 || exp_mr_q.size() != 0 || exp_ma_q.size() != 0) begin errors++; $display("FAIL mono_leftover actual=%0d required=0", exp_ml_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n; bit ok;
    clear_counts();
    lready = 1'b1; rready = 1'b0;
    push_stereo(0);
    go_stereo(2'd0);
    for (int f = 0; f < WL; f++) begin
      n = 0; ok = 1'b0;
      while (n < 20 && !ok) begin
        @(negedge clk); n++;
        if (s_lvalid === 1'b0 && s_rvalid === 1'b1) ok = 1'b1;
      end
      checks++; if (!ok) begin errors++; $display("FAIL bp_left_only_timeout actual=none required=frame%0d", f); end
      repeat (5) begin
        @(negedge clk);
        checks++;
        if (s_rvalid !== 1'b1 || s_lvalid !== 1'b0 || s_rden !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall actual=rv%b lv%b rden%b required=rv1 lv0 rden0", s_rvalid, s_lvalid, s_rden);
        end
      end
      @(posedge clk); #1 rready = 1'b1;
      @(posedge clk); #1 rready = 1'b0;
    end
    wait_done_s(20, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout actual=none required=done"); end
    checks++; if (s_rden_cnt !== WL || s_lhs_cnt !== WL || s_rhs_cnt !== WL) begin errors++; $display("FAIL bp_counts actual=%0d/%0d/%0d required=4/4/4", s_rden_cnt, s_lhs_cnt, s_rhs_cnt); end
    rready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_busy();
    int n; bit ok;
    clear_counts();
    lready = 1'b1; rready = 1'b1;
    push_stereo(1);
    go_stereo(2'd1);
    repeat (3) begin
      repeat (3) @(posedge clk);
      #1 s_ws = 2'd0; s_go = 1'b1;
      @(posedge clk); #1 s_go = 1'b0;
    end
    wait_done_s(30, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout actual=none required=done"); end
    s_go = 1'b1; s_ws = 2'd0;
    @(posedge clk); #1 s_go = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (s_done_cnt !== 1 || s_rden_cnt !== WL) begin errors++; $display("FAIL busy_counts actual=%0d/%0d required=1/4", s_done_cnt, s_rden_cnt); end
    checks++; if (s_go_out !== 1'b1 || s_state !== 3'd0) begin errors++; $display("FAIL busy_idle actual=%b/%0d required=1/0", s_go_out, s_state); end
  endtask

  task automatic test_win_err();
    clear_counts();
    @(posedge clk); #1 s_ws = 2'd3; s_go = 1'b1;
    @(posedge clk); #1 s_go = 1'b0;
    @(negedge clk);
    checks++; if (s_win_err !== 1'b1 || s_go_out !== 1'b1) begin errors++; $display("FAIL werr_pulse actual=%b%b required=11", s_win_err, s_go_out); end
    @(negedge clk);
    checks++; if (s_win_err !== 1'b0) begin errors++; $display("FAIL werr_width actual=%b required=0", s_win_err); end
    repeat (8) @(negedge clk);
    checks++; if (s_rden_cnt !== 0 || s_go_out !== 1'b1 || s_state !== 3'd0) begin errors++; $display("FAIL werr_idle actual=%0d/%b/%0d required=0/1/0", s_rden_cnt, s_go_out, s_state); end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    clear_counts();
    lready = 1'b1; rready = 1'b1;
    push_stereo(2);
    go_stereo(2'd2);
    n = 0;
    while (n < 30 && !(s_rden_cnt == 3 && s_lvalid === 1'b1)) begin @(negedge clk); n++; end
    checks++; if (n >= 30) begin errors++; $display("FAIL rmid_reach_frame2 actual=timeout required=frame2"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (s_lvalid !== 1'b0 || s_rvalid !== 1'b0 || s_rden !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL rmid_async actual=%b%b%b%b required=0000", s_lvalid, s_rvalid, s_rden, s_done); end
    checks++; if (s_go_out !== 1'b1 || s_state !== 3'd0) begin errors++; $display("FAIL rmid_go_out actual=%b/%0d required=1/0", s_go_out, s_state); end
    flush_queues();
    @(posedge clk); #1 reset_n = 1'b1;
    clear_counts();
    push_stereo(2);
    go_stereo(2'd2);
    wait_done_s(40, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_done_timeout actual=none required=done"); end
    @(negedge clk);
    checks++; if (s_lhs_cnt !== WL || s_rhs_cnt !== WL || s_done_cnt !== 1) begin errors++; $display("FAIL rmid_counts actual=%0d/%0d/%0d required=4/4/1", s_lhs_cnt, s_rhs_cnt, s_done_cnt); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NW * WL; i++) mem[i] = $urandom_range(32'hFFFF_FFFF, 0);
    s_rdata = '0; m_rdata = '0;
    test_reset();
    test_stereo();
    test_mono();
    test_backpressure();
    test_busy();
    test_win_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_emitter.md
Name: stream_emitter

Overview:
- Parametrised Avalon-ST playback engine.
- On a go request from the stitcher, reads one window of processed samples from the output buffer RAM and writes them to the Wolfson codec's left and right to_dac sinks.
- Signals completion back to the stitcher.
- Successor to the single-window stub: real buffer reads, per-channel ready/valid, configurable window geometry and mono/stereo mode.

Parameters:
- DATA_W, 16, sample width per channel.
- WIN_LEN, 512, samples (frames) per window.
- NUM_WIN, 4, number of windows in the output buffer.
- STEREO, 0, 0 = mono: low DATA_W bits of the buffer word go to both channels; 1 = buffer word is {right, left}.
- WIN_W, $clog2(NUM_WIN), window select width (derived).
- AW, $clog2(NUM_WIN*WIN_LEN), buffer address width (derived).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- window_start  in  WIN_W  window index to play, sampled on accepted go_in
- go_in  in  1  start request, single-cycle pulse
- go_out  out  1  level; 1 = idle/ready, 0 = playing
- done  out  1  one-cycle pulse after last frame of window accepted by both channels
- win_err  out  1  one-cycle pulse when go_in carries window_start >= NUM_WIN
- buf_addr  out  AW  output-buffer read address
- buf_rden  out  1  output-buffer read enable
- buf_rdata  in  2*DATA_W  read data, valid exactly 1 cycle after buf_rden
- left_out_data  out  DATA_W  Avalon-ST data to codec left sink
- left_out_valid  out  1  left valid
- left_out_ready  in  1  left ready
- right_out_data  out  DATA_W  Avalon-ST data to codec right sink
- right_out_valid  out  1  right valid
- right_out_ready  in  1  right ready

Behaviour:
- Reset values (async, reset_n low), all outputs registered:
  - go_out=1; done=0; win_err=0; buf_rden=0; buf_addr=0.
  - left/right_out_valid=0; left/right_out_data=0.
  - FSM=IDLE; frame counter=0.
- FSM states IDLE, READ, LATCH, PRESENT, FIN.
- IDLE: go_in=1 with window_start<NUM_WIN starts playback:
  - Latch base=window_start*WIN_LEN; counter=0; go_out<=0; go to READ.
  - If window_start>=NUM_WIN: win_err pulses 1 cycle, stay IDLE, go_out stays 1.
- READ (1 cycle): buf_rden=1, buf_addr=base+counter; go to LATCH.
- LATCH (1 cycle): buf_rden=0; register buf_rdata into output data regs; set both valids=1; go to PRESENT.
  - STEREO=1: left=rdata[DATA_W-1:0], right=rdata[2*DATA_W-1:DATA_W].
  - STEREO=0: both channels = rdata[DATA_W-1:0].
- PRESENT, per channel independently:
  - Handshake completes when valid && ready on a rising edge; that channel's valid drops next cycle.
  - Data on a channel is held stable while its valid=1.
  - Once both channels have completed (same or different cycles):
    - counter==WIN_LEN-1 -> FIN.
    - else counter+1 -> READ.
- FIN (1 cycle): done=1, go_out<=1, return to IDLE.
  - go_out is observed 1 the cycle after done.
  - A go_in arriving in the cycle done is high is ignored.
- Throughput: minimum 3 cycles per frame when both readies are held high. Codec frame rate is far lower.
- Latency:
  - go_in to first buf_rden: 1 cycle.
  - go_in to first valid: 3 cycles.
- go_in while go_out=0 is ignored: no restart, no error.
- window_start changing mid-playback has no effect; base is latched at start.
- Ready deasserted indefinitely: block stalls in PRESENT with valid high; no timeout.
- Address never leaves [base, base+WIN_LEN-1]. Last window ends at NUM_WIN*WIN_LEN-1 with no wrap.
- Reset asserted mid-playback: immediately returns all outputs to reset values; no done pulse; the partial window is abandoned.

Test Plan:
- Basic stereo (STEREO=1, WIN_LEN=4, readies tied 1): go_in with window_start=2.
  - buf_addr sequence 8,9,10,11.
  - 4 handshakes per channel, left=word[15:0], right=word[31:16].
  - done pulses once ~12 cycles after go_in; go_out 0 during, 1 after.
- Mono duplication (STEREO=0): buffer word 0xABCD1234.
  - Both channels emit 0x1234; upper half never appears.
- Skewed backpressure: right_out_ready low 5 cycles after left accepts.
  - left_out_valid drops after its handshake; right holds data stable.
  - Next buf_rden only after right accepts; frame count still WIN_LEN.
- Busy/illegal requests:
  - go_in during playback: no address restart, single done.
  - NUM_WIN=3 with window_start=3: win_err 1-cycle pulse, buf_rden never asserts, go_out stays 1.
- Reset mid-window: reset_n low during frame 2 PRESENT.
  - valids, buf_rden, done go 0 asynchronously; go_out=1.
  - New go_in after release plays the full window from frame 0.
